// File: rtl/issue_reorder_buf.sv
// issue_reorder_buf: issue-side reorder window between the instruction queue
// and the issue stage. It holds up to DEPTH decoded entries in program order,
// with entry 0 the oldest, and keeps them compacted.
//
// Optional feature (macro ISSUE_REORDER_EN):
//   defined   - when the oldest entry is a load/store and the LSU is stalled,
//               the oldest independent ALU entry is issued in its place. The
//               number of consecutive bypasses is bounded by MAX_BYPASS.
//   undefined - strict in-order FIFO with the same ports, pass-through and
//               flush behaviour; lsu_ready_i and debug_req_i are ignored.
module issue_reorder_buf #(
    parameter int DEPTH      = 4,
    parameter int PAYLOAD_W  = 64,
    parameter int REG_W      = 5,
    parameter int MAX_BYPASS = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         debug_req_i,
    input  logic                         in_valid_i,
    input  logic [PAYLOAD_W-1:0]         in_payload_i,
    input  logic [1:0]                   in_class_i,
    input  logic [REG_W-1:0]             in_rs1_i,
    input  logic [REG_W-1:0]             in_rs2_i,
    input  logic [REG_W-1:0]             in_rd_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [PAYLOAD_W-1:0]         out_payload_o,
    output logic [1:0]                   out_class_o,
    input  logic                         out_ack_i,
    input  logic                         lsu_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Class encoding; codes 2 and 3 are both control flow (bit 1 set).
    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_MEM = 2'd1;

    // Window storage, entry 0 is the oldest.
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    logic [1:0]           cls_q [DEPTH];
    logic [1:0]           cls_d [DEPTH];
    logic [REG_W-1:0]     rs1_q [DEPTH];
    logic [REG_W-1:0]     rs1_d [DEPTH];
    logic [REG_W-1:0]     rs2_q [DEPTH];
    logic [REG_W-1:0]     rs2_d [DEPTH];
    logic [REG_W-1:0]     rd_q  [DEPTH];
    logic [REG_W-1:0]     rd_d  [DEPTH];

    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_d;

    // Handshake and bookkeeping signals.
    logic                 empty_s;
    logic                 pass_s;
    logic                 deq_s;
    logic                 enq_s;
    logic                 cons_pass_s;
    logic                 shift_s;
    logic                 store_s;
    logic [OCC_W-1:0]     tail_s;
    logic [IDX_W-1:0]     tail_idx_s;
    logic [IDX_W-1:0]     sel_s;

    // Younger entry i conflicts with older entry j through RAW, WAR or WAW.
    // A comparison against destination x0 never creates a dependency.
    function automatic logic hazard_f(
        input logic [REG_W-1:0] rd_j,
        input logic [REG_W-1:0] rs1_j,
        input logic [REG_W-1:0] rs2_j,
        input logic [REG_W-1:0] rd_i,
        input logic [REG_W-1:0] rs1_i,
        input logic [REG_W-1:0] rs2_i
    );
        logic raw;
        logic war_waw;
        raw     = (rd_j != {REG_W{1'b0}}) && ((rd_j == rs1_i) || (rd_j == rs2_i));
        war_waw = (rd_i != {REG_W{1'b0}}) &&
                  ((rd_i == rs1_j) || (rd_i == rs2_j) || (rd_i == rd_j));
        return raw || war_waw;
    endfunction

`ifdef ISSUE_REORDER_EN
    localparam int BYP_W = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;

    logic [BYP_W-1:0] byp_q;
    logic [BYP_W-1:0] byp_d;
    logic             byp_ok_s;
    logic             found_s;
    logic             ctrl_seen_s;
    logic             haz_s;
    logic             cand_s;

    // Pick the oldest independent ALU entry when the memory head is stalled.
    always_comb begin
        byp_ok_s    = (cls_q[0] == CLS_MEM) && !lsu_ready_i && !debug_req_i &&
                      (byp_q < BYP_W'(MAX_BYPASS));
        sel_s       = {IDX_W{1'b0}};
        found_s     = 1'b0;
        ctrl_seen_s = 1'b0;
        haz_s       = 1'b0;
        cand_s      = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            // Control flow anywhere older than i stops the search from going past it.
            ctrl_seen_s = ctrl_seen_s | cls_q[i-1][1];
            haz_s       = 1'b0;
            for (int j = 0; j < i; j++) begin
                haz_s = haz_s | hazard_f(rd_q[j], rs1_q[j], rs2_q[j],
                                         rd_q[i], rs1_q[i], rs2_q[i]);
            end
            cand_s  = byp_ok_s && !found_s && (i < int'(occ_q)) &&
                      (cls_q[i] == CLS_ALU) && !ctrl_seen_s && !haz_s;
            sel_s   = cand_s ? IDX_W'(i) : sel_s;
            found_s = found_s | cand_s;
        end
    end

    // Count consecutive acked bypasses; a head issue or flush restarts the count.
    always_comb begin
        if (flush_i) begin
            byp_d = {BYP_W{1'b0}};
        end else if (shift_s) begin
            if (sel_s == {IDX_W{1'b0}}) begin
                byp_d = {BYP_W{1'b0}};
            end else if (byp_q < BYP_W'(MAX_BYPASS)) begin
                byp_d = byp_q + {{(BYP_W-1){1'b0}}, 1'b1};
            end else begin
                byp_d = byp_q;
            end
        end else begin
            byp_d = byp_q;
        end
    end

    // Bypass counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byp_q <= {BYP_W{1'b0}};
        end else begin
            byp_q <= byp_d;
        end
    end
`else
    logic unused_acc_s;

    assign sel_s = {IDX_W{1'b0}};

    // In-order build: operand fields and LSU/debug inputs carry no meaning here.
    always_comb begin
        unused_acc_s = lsu_ready_i ^ debug_req_i;
        for (int k = 0; k < DEPTH; k++) begin
            unused_acc_s = unused_acc_s ^ (^{rs1_q[k], rs2_q[k], rd_q[k]});
        end
    end
`endif

    // Handshakes, outputs and write position of an accepted entry.
    always_comb begin
        empty_s       = (occ_q == {OCC_W{1'b0}});
        pass_s        = empty_s && in_valid_i;
        in_ready_o    = (occ_q < OCC_W'(DEPTH));
        out_valid_o   = !empty_s || in_valid_i;
        if (empty_s) begin
            out_payload_o = in_payload_i;
            out_class_o   = in_class_i;
        end else begin
            out_payload_o = pay_q[sel_s];
            out_class_o   = cls_q[sel_s];
        end
        deq_s         = out_valid_o && out_ack_i;
        enq_s         = in_valid_i && in_ready_o;
        // Empty-window input consumed in the same cycle never touches storage.
        cons_pass_s   = pass_s && out_ack_i;
        shift_s       = deq_s && !empty_s;
        store_s       = enq_s && !cons_pass_s;
        tail_s        = shift_s ? (occ_q - {{(OCC_W-1){1'b0}}, 1'b1}) : occ_q;
        tail_idx_s    = tail_s[IDX_W-1:0];
        occupancy_o   = occ_q;
    end

    // Remove the issued entry, compact the younger ones, append the new entry.
    always_comb begin
        pay_d = pay_q;
        cls_d = cls_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = {OCC_W{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                if (shift_s && (k >= int'(sel_s))) begin
                    pay_d[k] = pay_q[k+1];
                    cls_d[k] = cls_q[k+1];
                    rs1_d[k] = rs1_q[k+1];
                    rs2_d[k] = rs2_q[k+1];
                    rd_d[k]  = rd_q[k+1];
                end else begin
                    pay_d[k] = pay_q[k];
                    cls_d[k] = cls_q[k];
                    rs1_d[k] = rs1_q[k];
                    rs2_d[k] = rs2_q[k];
                    rd_d[k]  = rd_q[k];
                end
            end
            if (store_s) begin
                pay_d[tail_idx_s] = in_payload_i;
                cls_d[tail_idx_s] = in_class_i;
                rs1_d[tail_idx_s] = in_rs1_i;
                rs2_d[tail_idx_s] = in_rs2_i;
                rd_d[tail_idx_s]  = in_rd_i;
            end else begin
                pay_d[tail_idx_s] = pay_d[tail_idx_s];
            end
            occ_d = occ_q + {{(OCC_W-1){1'b0}}, store_s}
                          - {{(OCC_W-1){1'b0}}, shift_s};
        end
    end

    // Window storage and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= {OCC_W{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                pay_q[k] <= {PAYLOAD_W{1'b0}};
                cls_q[k] <= 2'd0;
                rs1_q[k] <= {REG_W{1'b0}};
                rs2_q[k] <= {REG_W{1'b0}};
                rd_q[k]  <= {REG_W{1'b0}};
            end
        end else begin
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                pay_q[k] <= pay_d[k];
                cls_q[k] <= cls_d[k];
                rs1_q[k] <= rs1_d[k];
                rs2_q[k] <= rs2_d[k];
                rd_q[k]  <= rd_d[k];
            end
        end
    end

endmodule
